// File: rtl/lcd_bus_arbiter_if.sv
// Bus bundle between the LCD write-bus arbiter and its sources / LCD controller.
// The arbiter connects through the slave modport; the source side and the
// LCD controller side together form the master view.
interface lcd_bus_arbiter_if #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]         lcd_data;
    logic                      lcd_wr;
    logic [NUM_SRC-1:0]        grant;
    logic                      busy;

    modport master (
        output src_valid, src_data, src_last,
        input  src_ready, lcd_data, lcd_wr, grant, busy
    );

    modport slave (
        input  src_valid, src_data, src_last,
        output src_ready, lcd_data, lcd_wr, grant, busy
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// N-source arbiter/mux for the 8-bit LCD controller write bus.
// A source handshakes one beat at a time; the grant is held for a whole packet
// (until the beat flagged last has completed its HOLD phase). Each beat is
// presented with SETUP / STROBE / HOLD timing on the registered lcd_wr strobe.
// Optional feature: define LCD_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with source 0 (init ROM) highest.
module lcd_bus_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_arbiter_if.slave bus
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    // Isolates the lowest set bit of a request vector.
    function automatic logic [NUM_SRC-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
        return v & (~v + NUM_SRC'(1));
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_lcd_data;
    logic                r_lcd_wr;
    logic [NUM_SRC-1:0]  r_grant;
    logic                r_busy;
    logic                r_last;

    logic [NUM_SRC-1:0]  w_arb_oh;
    logic [NUM_SRC-1:0]  w_src_ready;
    logic [NUM_SRC-1:0]  w_sel_oh;
    logic                w_accept;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_last;
    logic [NUM_SRC-1:0]  w_grant_nxt;
    logic                w_lcd_wr_nxt;
    logic                w_busy_nxt;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Converts a one-hot grant into the owning source index.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = idx | (oh[i] ? PTR_W'(i) : '0);
        end
        return idx;
    endfunction

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_owner_idx;
    logic [2*NUM_SRC-1:0] w_rot_dbl;
    logic [NUM_SRC-1:0]   w_rot_oh;
    logic [2*NUM_SRC-1:0] w_back_dbl;

    // Round-robin pick: rotate requests so the pointer sits at bit 0, take the
    // lowest requester, rotate the one-hot result back.
    always_comb begin
        w_rot_dbl  = {bus.src_valid, bus.src_valid} >> r_ptr;
        w_rot_oh   = lowest_set(w_rot_dbl[NUM_SRC-1:0]);
        w_back_dbl = {w_rot_oh, w_rot_oh} << r_ptr;
        w_arb_oh   = w_back_dbl[2*NUM_SRC-1:NUM_SRC];
    end

    assign w_owner_idx = onehot_to_idx(r_grant);

    // Pointer moves past the owner when its packet finishes (HOLD -> IDLE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if ((r_state == S_HOLD) && (w_next_state == S_IDLE)) begin
            r_ptr <= (w_owner_idx == PTR_W'(NUM_SRC - 1)) ? '0 : (w_owner_idx + PTR_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    assign w_arb_oh = lowest_set(bus.src_valid);
`endif

    // State register and phase down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a phase ends when its counter has run down to zero.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (|bus.src_valid) w_next_state = S_SETUP;
                else                w_next_state = S_IDLE;
            end
            S_SETUP: begin
                if (r_cnt == '0) w_next_state = S_STROBE;
                else             w_next_state = S_SETUP;
            end
            S_STROBE: begin
                if (r_cnt == '0) w_next_state = S_HOLD;
                else             w_next_state = S_STROBE;
            end
            S_HOLD: begin
                if (r_cnt != '0) w_next_state = S_HOLD;
                else if (r_last) w_next_state = S_IDLE;
                else             w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (|(bus.src_valid & r_grant)) w_next_state = S_SETUP;
                else                            w_next_state = S_WAIT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: ready/selection, beat mux, counter reload and next values
    // of the registered bus outputs.
    always_comb begin
        w_src_ready = '0;
        if (rst) begin
            w_src_ready = '0;
        end else begin
            case (r_state)
                S_IDLE:  w_src_ready = w_arb_oh;
                S_WAIT:  w_src_ready = r_grant;
                default: w_src_ready = '0;
            endcase
        end

        w_sel_oh   = bus.src_valid & w_src_ready;
        w_accept   = |w_sel_oh;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel_data = w_sel_data | (bus.src_data[i*DATA_W +: DATA_W] & {DATA_W{w_sel_oh[i]}});
            w_sel_last = w_sel_last | (bus.src_last[i] & w_sel_oh[i]);
        end

        w_cnt_nxt = r_cnt;
        if (w_next_state != r_state) begin
            case (w_next_state)
                S_SETUP:  w_cnt_nxt = CNT_W'(SETUP_CYC - 1);
                S_STROBE: w_cnt_nxt = CNT_W'(STROBE_CYC - 1);
                S_HOLD:   w_cnt_nxt = CNT_W'(HOLD_CYC - 1);
                default:  w_cnt_nxt = '0;
            endcase
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end

        w_lcd_wr_nxt = (w_next_state == S_STROBE);
        w_busy_nxt   = (w_next_state != S_IDLE);

        if (w_accept) begin
            w_grant_nxt = w_sel_oh;
        end else if (w_next_state == S_IDLE) begin
            w_grant_nxt = '0;
        end else begin
            w_grant_nxt = r_grant;
        end
    end

    // Registered LCD-side outputs; data and last flag only change on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcd_data <= '0;
            r_last     <= 1'b0;
            r_lcd_wr   <= 1'b0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lcd_data <= w_sel_data;
                r_last     <= w_sel_last;
            end else begin
                r_lcd_data <= r_lcd_data;
                r_last     <= r_last;
            end
            r_lcd_wr <= w_lcd_wr_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.lcd_data  = r_lcd_data;
    assign bus.lcd_wr    = r_lcd_wr;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;

endmodule
